mnist_layer_sequencer: RTL and testbench
========================================

Name: mnist_layer_sequencer

Overview:
- Central control FSM of the MNIST accelerator. Sequences one inference per start request: image load, layer-1 MAC sweep over all pixels, ReLU, layer-2 MAC sweep over hidden activations, and argmax latch.
- Drives row/layer addressing to the weight memory, plus enable/clear strobes to both MAC arrays, the ReLU unit and the argmax latch.
- Reports busy, done and an elapsed-cycle counter.

Parameters:
- IMG_SIZE, 784, layer-1 input count (pixels); row_idx sweep length in L1.
- HID_SIZE, 32, layer-2 input count (hidden neurons); row_idx sweep length in L2.
- RELU_CYC, 2, cycles apply_relu is held (min 1).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-low reset (0 = reset), same name as used throughout the codebase.
- start  in  1  level request; a run begins when sampled high in IDLE.
- done  out  1  high in DONE state.
- busy  out  1  high in every state except IDLE and DONE.
- layer_sel  out  2  memory bank select: 0 = none/load, 1 = L1, 2 = L2, 3 = argmax.
- row_idx  out  10  current input index within the active layer.
- mac_en_l1  out  1  L1 MAC accumulate enable.
- mac_clr_l1  out  1  L1 MAC clear strobe.
- mac_en_l2  out  1  L2 MAC accumulate enable.
- mac_clr_l2  out  1  L2 MAC clear strobe.
- load_img  out  1  image buffer capture strobe.
- comp_l1  out  1  L1 compute phase flag.
- apply_relu  out  1  ReLU phase flag.
- comp_l2  out  1  L2 compute phase flag.
- find_max  out  1  argmax latch strobe.
- cycle_cnt  out  10  cycles elapsed in current run.

Behaviour:
- Reset (rst=0, async): state=IDLE; all outputs 0, including row_idx, cycle_cnt and layer_sel.
- All outputs are registered (Moore, decoded from the state register). A state is visible on outputs in the cycle it occupies.
- IDLE: everything 0. If start=1 at a rising edge, go to LOAD and set cycle_cnt=0.
- LOAD (1 cycle): load_img=1, busy=1, layer_sel=0. Go to L1_CLR.
- L1_CLR (1 cycle): mac_clr_l1=1, layer_sel=1, row_idx=0. Go to L1_COMP.
- L1_COMP (IMG_SIZE cycles): comp_l1=1, mac_en_l1=1, layer_sel=1. row_idx runs 0,1,…,IMG_SIZE-1, one step per cycle. After row_idx=IMG_SIZE-1, go to RELU; row_idx returns to 0.
- RELU (RELU_CYC cycles): apply_relu=1, layer_sel=1. Go to L2_CLR.
- L2_CLR (1 cycle): mac_clr_l2=1, layer_sel=2, row_idx=0. Go to L2_COMP.
- L2_COMP (HID_SIZE cycles): comp_l2=1, mac_en_l2=1, layer_sel=2. row_idx runs 0..HID_SIZE-1. Then go to ARGMAX.
- ARGMAX (1 cycle): find_max=1, layer_sel=3. Go to DONE.
- DONE: done=1, busy=0, and all strobes 0. Stays in DONE while start=1; returns to IDLE when start=0. A new run needs start to go low and then high again.
- Strobe exclusivity: at most one of load_img, mac_clr_*, comp_l1, apply_relu, comp_l2, find_max is high in any cycle. mac_en_lX equals comp_lX.
- cycle_cnt: 0 in LOAD, +1 every cycle while busy, saturates at 1023, frozen in DONE. Defaults give 822 in DONE: 1+1+784+2+1+32+1.
- row_idx never exceeds max(IMG_SIZE, HID_SIZE)-1 and is 0 outside the COMP and CLR states.
- start deasserted mid-run: ignored; the run completes.
- rst asserted mid-run: immediate return to IDLE with all outputs 0.

Optional Feature:
- Macro SEQ_SOFT_ABORT_EN.
- Defined: extra input port abort (1 bit). abort=1 at a rising edge in any busy state forces IDLE on the next cycle. All strobes drop, done is never asserted for that run, and cycle_cnt holds its last value.
- Undefined: no abort port; runs always complete.

Decomposition:
- Shared package mnist_pkg holds:
  - IMG_SIZE, HID_SIZE, OUT_SIZE (10)
  - ACC_W (20), DATA_W (8)
  - layer_sel encodings
  - state enum: IDLE, LOAD, L1_CLR, L1_COMP, RELU, L2_CLR, L2_COMP, ARGMAX, DONE
- Sub-module: mnist_row_counter, a loadable/clearable 10-bit counter with terminal-count flag. It is reused for the L1/L2 sweeps and the RELU phase.

Test Plan:
- Reset then idle: rst=0 then 1, start=0 for 10 cycles → all outputs 0, busy=0.
- Full run: start held high → load_img for exactly 1 cycle; comp_l1 for 784 cycles with row_idx 0..783; apply_relu for 2 cycles; comp_l2 for 32 cycles with row_idx 0..31; find_max for 1 cycle; then done=1 with cycle_cnt=822.
- Done handshake: keep start=1 after done → stays DONE, no second run. Drop start → IDLE next cycle. Raise start → new run, cycle_cnt restarts at 0.
- Mid-run reset: assert rst=0 when row_idx=400 in L1_COMP → state IDLE and all outputs 0 immediately (asynchronous); a later start runs the full 822-cycle sequence.
- Strobe checks: every cycle assert one-hot/zero of phase strobes, mac_en_lX==comp_lX, row_idx=0 in L1_CLR/L2_CLR, and layer_sel matches the state.
- With SEQ_SOFT_ABORT_EN: abort=1 at L2_COMP row_idx=5 → IDLE next cycle, done never rises, cycle_cnt held.

Source files
------------

// File: rtl/mnist_pkg.sv
// Shared definitions for the MNIST accelerator: layer sizes, datapath widths,
// memory bank select encodings and the layer sequencer state set.
package mnist_pkg;

  localparam int IMG_SIZE = 784;  // layer-1 inputs (pixels)
  localparam int HID_SIZE = 32;   // layer-2 inputs (hidden neurons)
  localparam int OUT_SIZE = 10;   // output classes
  localparam int ACC_W    = 20;   // MAC accumulator width
  localparam int DATA_W   = 8;    // pixel / weight width
  localparam int RELU_CYC = 2;    // cycles the ReLU phase is held (>= 1)
  localparam int ROW_W    = 10;   // row index / sweep counter width
  localparam int CNT_W    = 10;   // elapsed-cycle counter width

  // Weight memory bank select
  typedef enum logic [1:0] {
    SEL_NONE   = 2'd0,
    SEL_L1     = 2'd1,
    SEL_L2     = 2'd2,
    SEL_ARGMAX = 2'd3
  } layer_sel_e;

  typedef enum logic [3:0] {
    IDLE, LOAD, L1_CLR, L1_COMP, RELU, L2_CLR, L2_COMP, ARGMAX, DONE
  } state_e;

  // A run is in progress in every state except IDLE and DONE.
  function automatic logic is_busy(input state_e s);
    return (s != IDLE) && (s != DONE);
  endfunction

endpackage

// File: rtl/mnist_row_counter.sv
// Clearable up-counter with a terminal-count flag. The sequencer uses one
// instance for the L1 sweep, the ReLU hold and the L2 sweep by changing the
// terminal value per state. Clear has priority over enable.
module mnist_row_counter #(
  parameter int W = 10
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] term,
  output logic [W-1:0] cnt,
  output logic         tc
);

  logic [W-1:0] cnt_q, cnt_d;

  // Next count: clear wins, otherwise step when enabled.
  always_comb begin
    cnt_d = cnt_q;
    if (clr)     cnt_d = '0;
    else if (en) cnt_d = cnt_q + 1'b1;
  end

  // Count register.
  // NOTE: sequential state is written with <= only, so every flop samples
  // pre-edge values regardless of block ordering in simulation.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end

  assign cnt = cnt_q;
  assign tc  = (cnt_q == term);

endmodule

// File: rtl/mnist_layer_sequencer.sv
// Central control FSM of the MNIST accelerator: one inference per start
// request (load, L1 sweep, ReLU, L2 sweep, argmax latch), Moore outputs
// decoded from the state register.
// Optional: define SEQ_SOFT_ABORT_EN to add an 'abort' input that returns any
// busy state to IDLE, holding cycle_cnt and never raising done.
module mnist_layer_sequencer
  import mnist_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SEQ_SOFT_ABORT_EN
  input  logic             abort,
`endif
  output logic             done,
  output logic             busy,
  output logic [1:0]       layer_sel,
  output logic [ROW_W-1:0] row_idx,
  output logic             mac_en_l1,
  output logic             mac_clr_l1,
  output logic             mac_en_l2,
  output logic             mac_clr_l2,
  output logic             load_img,
  output logic             comp_l1,
  output logic             apply_relu,
  output logic             comp_l2,
  output logic             find_max,
  output logic [CNT_W-1:0] cycle_cnt
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [ROW_W-1:0] row_cnt, row_term;
  logic             row_tc, row_clr, row_en;
  logic             abort_hit;

  // Soft abort request, only meaningful while a run is in progress.
  always_comb begin
`ifdef SEQ_SOFT_ABORT_EN
    abort_hit = abort && is_busy(state_q);
`else
    abort_hit = 1'b0;
`endif
  end

  // Terminal sweep value for the phase currently being timed.
  always_comb begin
    case (state_q)
      L1_COMP: row_term = ROW_W'(IMG_SIZE - 1);
      RELU:    row_term = ROW_W'(RELU_CYC - 1);
      L2_COMP: row_term = ROW_W'(HID_SIZE - 1);
      default: row_term = '0;
    endcase
  end

  // Next-state logic.
  // NOTE: every always_comb output gets a default first, so no path can
  // leave it unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = LOAD;
      LOAD:    state_d = L1_CLR;
      L1_CLR:  state_d = L1_COMP;
      L1_COMP: if (row_tc) state_d = RELU;
      RELU:    if (row_tc) state_d = L2_CLR;
      L2_CLR:  state_d = L2_COMP;
      L2_COMP: if (row_tc) state_d = ARGMAX;
      ARGMAX:  state_d = DONE;
      DONE:    if (!start) state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  // The sweep counter restarts on every state change and runs only in the
  // timed phases.
  assign row_clr = (state_d != state_q);
  assign row_en  = (state_q == L1_COMP) || (state_q == RELU) || (state_q == L2_COMP);

  mnist_row_counter #(.W(ROW_W)) u_row_cnt (
    .clk  (clk),
    .rst  (rst),
    .clr  (row_clr),
    .en   (row_en),
    .term (row_term),
    .cnt  (row_cnt),
    .tc   (row_tc)
  );

  // Elapsed cycles: zero on entry to LOAD, saturating step while busy,
  // frozen in DONE, cleared when a completed run returns to IDLE and held
  // when a run is aborted.
  always_comb begin
    cyc_d = cyc_q;
    if (state_q == IDLE && state_d == LOAD)
      cyc_d = '0;
    else if (state_q == DONE && state_d == IDLE)
      cyc_d = '0;
    else if (is_busy(state_q) && !abort_hit)
      cyc_d = (cyc_q == '1) ? cyc_q : cyc_q + 1'b1;
  end

  // State and elapsed-cycle registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      cyc_q   <= '0;
    end else begin
      state_q <= state_d;
      cyc_q   <= cyc_d;
    end
  end

  // Moore output decode.
  always_comb begin
    layer_sel  = SEL_NONE;
    load_img   = 1'b0;
    mac_clr_l1 = 1'b0;
    comp_l1    = 1'b0;
    apply_relu = 1'b0;
    mac_clr_l2 = 1'b0;
    comp_l2    = 1'b0;
    find_max   = 1'b0;
    case (state_q)
      LOAD:    load_img = 1'b1;
      L1_CLR:  begin mac_clr_l1 = 1'b1; layer_sel = SEL_L1; end
      L1_COMP: begin comp_l1    = 1'b1; layer_sel = SEL_L1; end
      RELU:    begin apply_relu = 1'b1; layer_sel = SEL_L1; end
      L2_CLR:  begin mac_clr_l2 = 1'b1; layer_sel = SEL_L2; end
      L2_COMP: begin comp_l2    = 1'b1; layer_sel = SEL_L2; end
      ARGMAX:  begin find_max   = 1'b1; layer_sel = SEL_ARGMAX; end
      default: ;
    endcase
  end

  assign mac_en_l1 = comp_l1;
  assign mac_en_l2 = comp_l2;
  assign busy      = is_busy(state_q);
  assign done      = (state_q == DONE);
  assign row_idx   = (comp_l1 || comp_l2) ? row_cnt : '0;
  assign cycle_cnt = cyc_q;

endmodule

// File: tb/tb_mnist_layer_sequencer.sv
// Self-checking bench for mnist_layer_sequencer. A run is modelled as a
// position k counted from the LOAD cycle; the expected outputs at k follow
// from the phase lengths alone.
module tb_mnist_layer_sequencer;
  import mnist_pkg::*;

  localparam int L1_START  = 2;
  localparam int RELU_ST   = L1_START + IMG_SIZE;
  localparam int L2CLR_ST  = RELU_ST + RELU_CYC;
  localparam int L2_START  = L2CLR_ST + 1;
  localparam int ARGMAX_ST = L2_START + HID_SIZE;
  localparam int T_DONE    = ARGMAX_ST + 1;   // 822 with default sizes

  typedef struct packed {
    logic             done;
    logic             busy;
    logic [1:0]       layer_sel;
    logic [ROW_W-1:0] row_idx;
    logic             mac_en_l1;
    logic             mac_clr_l1;
    logic             mac_en_l2;
    logic             mac_clr_l2;
    logic             load_img;
    logic             comp_l1;
    logic             apply_relu;
    logic             comp_l2;
    logic             find_max;
    logic [CNT_W-1:0] cycle_cnt;
  } obs_t;

  logic clk, rst, start;
`ifdef SEQ_SOFT_ABORT_EN
  logic abort;
`endif
  logic             done, busy;
  logic [1:0]       layer_sel;
  logic [ROW_W-1:0] row_idx;
  logic             mac_en_l1, mac_clr_l1, mac_en_l2, mac_clr_l2;
  logic             load_img, comp_l1, apply_relu, comp_l2, find_max;
  logic [CNT_W-1:0] cycle_cnt;
  obs_t             got;

  int n_checks = 0;
  int n_fail   = 0;
  int model_k  = -1;   // -1 = idle, 0..T_DONE-1 = run position, T_DONE = done
  int idle_cnt = 0;    // cycle_cnt expected while idle

  mnist_layer_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
`ifdef SEQ_SOFT_ABORT_EN
    .abort      (abort),
`endif
    .done       (done),
    .busy       (busy),
    .layer_sel  (layer_sel),
    .row_idx    (row_idx),
    .mac_en_l1  (mac_en_l1),
    .mac_clr_l1 (mac_clr_l1),
    .mac_en_l2  (mac_en_l2),
    .mac_clr_l2 (mac_clr_l2),
    .load_img   (load_img),
    .comp_l1    (comp_l1),
    .apply_relu (apply_relu),
    .comp_l2    (comp_l2),
    .find_max   (find_max),
    .cycle_cnt  (cycle_cnt)
  );

  assign got = {done, busy, layer_sel, row_idx, mac_en_l1, mac_clr_l1,
                mac_en_l2, mac_clr_l2, load_img, comp_l1, apply_relu,
                comp_l2, find_max, cycle_cnt};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h expected=%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected outputs at run position k.
  function automatic obs_t run_obs(input int k);
    obs_t o;
    o = '0;
    o.busy      = (k < T_DONE);
    o.done      = (k >= T_DONE);
    o.cycle_cnt = CNT_W'((k < T_DONE ? k : T_DONE) > 1023 ? 1023 : (k < T_DONE ? k : T_DONE));
    if (k == 0) o.load_img = 1'b1;
    else if (k == 1) begin
      o.mac_clr_l1 = 1'b1; o.layer_sel = 2'd1;
    end else if (k < RELU_ST) begin
      o.comp_l1 = 1'b1; o.mac_en_l1 = 1'b1; o.layer_sel = 2'd1;
      o.row_idx = ROW_W'(k - L1_START);
    end else if (k < L2CLR_ST) begin
      o.apply_relu = 1'b1; o.layer_sel = 2'd1;
    end else if (k == L2CLR_ST) begin
      o.mac_clr_l2 = 1'b1; o.layer_sel = 2'd2;
    end else if (k < ARGMAX_ST) begin
      o.comp_l2 = 1'b1; o.mac_en_l2 = 1'b1; o.layer_sel = 2'd2;
      o.row_idx = ROW_W'(k - L2_START);
    end else if (k == ARGMAX_ST) begin
      o.find_max = 1'b1; o.layer_sel = 2'd3;
    end
    return o;
  endfunction

  function automatic obs_t exp_obs();
    obs_t o;
    if (model_k < 0) begin
      o = '0;
      o.cycle_cnt = CNT_W'(idle_cnt);
    end else begin
      o = run_obs(model_k);
    end
    return o;
  endfunction

  // Advance the reference model by one clock edge using the sampled inputs.
  task automatic model_update();
    if (!rst) begin
      model_k = -1; idle_cnt = 0;
    end else if (model_k < 0) begin
      if (start) model_k = 0;
    end else if (model_k < T_DONE) begin
`ifdef SEQ_SOFT_ABORT_EN
      if (abort) begin idle_cnt = model_k; model_k = -1; end
      else model_k++;
`else
      model_k++;
`endif
    end else if (!start) begin
      model_k = -1; idle_cnt = 0;
    end
  endtask

  // One clock: update model at the edge, compare 1 ns later.
  task automatic cyc();
    @(posedge clk);
    model_update();
    #1;
    check($sformatf("outs@k=%0d", model_k), 64'(got), 64'(exp_obs()));
    check("strobe_excl",
          64'($countones({load_img, mac_clr_l1, mac_clr_l2, comp_l1,
                          apply_relu, comp_l2, find_max}) <= 1), 64'd1);
  endtask

  task automatic run_once(input bit do_reset, input bit do_abort);
    int budget;
    budget = 0;
    start = 1'b0;
    repeat ($urandom_range(0, 3)) cyc();
    start = 1'b1;
    cyc();
    check("run_start_cnt", 64'(cycle_cnt), 64'd0);
    while (model_k >= 0 && model_k < T_DONE && budget < 2000) begin
      budget++;
      if (do_reset && model_k == L1_START + 400) begin
        #2 rst = 1'b0;
        #1 model_k = -1; idle_cnt = 0;
        check("async_rst", 64'(got), 64'd0);
        repeat (2) cyc();
        rst = 1'b1; start = 1'b0;
        cyc();
        return;
      end
`ifdef SEQ_SOFT_ABORT_EN
      if (do_abort && model_k == L2_START + 5) begin
        start = 1'b0; abort = 1'b1;
        cyc();
        abort = 1'b0;
        check("abort_cnt_held", 64'(cycle_cnt), 64'(L2_START + 5));
      end else
`endif
      begin
        start = 1'($urandom_range(0, 1));
        cyc();
      end
    end
    if (budget >= 2000) check("run_budget", 64'(budget), 64'd0);
    if (model_k == T_DONE && !do_abort) begin
      check("done_cnt", 64'(cycle_cnt), 64'(T_DONE));
      start = 1'b1;
      repeat ($urandom_range(2, 8)) cyc();
      start = 1'b0;
      cyc();
      check("back_to_idle", 64'({done, busy}), 64'd0);
    end else begin
      start = 1'b0;
      repeat (3) cyc();
    end
  endtask

  initial begin
    rst = 1'b0; start = 1'b0;
`ifdef SEQ_SOFT_ABORT_EN
    abort = 1'b0;
`endif
    repeat (3) cyc();
    rst = 1'b1;
    repeat (10) cyc();
    run_once(1'b0, 1'b0);
    run_once(1'b0, 1'b0);
    run_once(1'b1, 1'b0);
    run_once(1'b0, 1'b0);
`ifdef SEQ_SOFT_ABORT_EN
    run_once(1'b0, 1'b1);
    run_once(1'b0, 1'b0);
`endif
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
